// File: rtl/inst_encoder_loader_pkg.sv
// Shared ISA constants, field bundle and FSM encoding for the
// instruction encoder/loader and its packing sub-module.
package inst_encoder_loader_pkg;

    typedef enum logic [2:0] {
        KIND_RTYPE = 3'd0,
        KIND_LW    = 3'd1,
        KIND_SW    = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_ORI   = 3'd4,
        KIND_J     = 3'd5
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE,
        S_ERR
    } state_e;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } fields_t;

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: instruction kind plus fields into a
// 32-bit MIPS word, flagging kinds that have no encoding.
module inst_pack
    import inst_encoder_loader_pkg::*;
(
    input  logic [2:0]  kind_i,
    input  fields_t     f_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        unique case (1'b1)
            (kind_i == KIND_RTYPE):
                word_o = {OP_RTYPE, f_i.rs, f_i.rt,
                          f_i.rd, f_i.shamt, f_i.funct};
            (kind_i == KIND_LW):
                word_o = {OP_LW, f_i.rs, f_i.rt, f_i.imm};
            (kind_i == KIND_SW):
                word_o = {OP_SW, f_i.rs, f_i.rt, f_i.imm};
            (kind_i == KIND_BEQ):
                word_o = {OP_BEQ, f_i.rs, f_i.rt, f_i.imm};
            (kind_i == KIND_ORI):
                word_o = {OP_ORI, f_i.rs, f_i.rt, f_i.imm};
            (kind_i == KIND_J):
                word_o = {OP_J, f_i.target};
            default:
                illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Streams encoded instructions into the imem write port: load FSM,
// address/count tracking and a registered one-cycle write stage.
module inst_encoder_loader
    import inst_encoder_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE_C   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        code_q, code_d;

    fields_t     fields;
    logic [31:0] word;
    logic        illegal;
    logic        accept;

    assign fields = '{rs: in_rs, rt: in_rt, rd: in_rd,
                      shamt: in_shamt, funct: in_funct,
                      imm: in_imm, target: in_target};

    inst_pack u_pack (
        .kind_i    (in_kind),
        .f_i       (fields),
        .word_o    (word),
        .illegal_o (illegal)
    );

    assign accept = (state_q == S_LOAD) && in_valid && !start;

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        code_d  = code_q;
        // addr_q tracks the word being presented; step past it once written
        if (we_q && addr_q != ADDR_MAX)
            addr_d = addr_q + 1'b1;
        if (start) begin
            state_d = S_LOAD;
            addr_d  = BASE_C;
            count_d = '0;
            code_d  = '0;
        end else if (accept) begin
            if (illegal) begin
                state_d = S_ERR;
                code_d  = ERR_ILLEGAL;
            end else begin
                we_d    = 1'b1;
                wdata_d = word;
                count_d = count_q + 1'b1;
                if (in_last) begin
                    state_d = S_DONE;
                end else if (count_d == DEPTH_C) begin
                    state_d = S_ERR;
                    code_d  = ERR_OVERFLOW;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= BASE_C;
            wdata_q <= '0;
            count_q <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            code_q  <= code_d;
        end
    end

    assign in_ready   = (state_q == S_LOAD);
    assign busy       = (state_q == S_LOAD);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign err_code   = code_q;
    assign count      = count_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Randomised bench for inst_encoder_loader against a behavioural
// model of the load session (expected words, addresses, states).
module tb_inst_encoder_loader;

    localparam int AW   = 4;
    localparam int BASE = 2;
    localparam int DEP  = 6;
    localparam int AMAX = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_kind = '0;
    logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]    in_funct = '0;
    logic [15:0]   in_imm = '0;
    logic [25:0]   in_target = '0;
    logic          in_last = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy, done, err;
    logic [1:0]    err_code;
    logic [AW:0]   count;

    int tests = 0;
    int fails = 0;

    bit m_load, m_done, m_err;
    int m_code, m_count, m_addr;

    inst_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(DEP)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_funct(in_funct), .in_imm(in_imm),
        .in_target(in_target), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .err_code(err_code),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(
        input int k, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
        input logic [15:0] imm, input logic [25:0] tg);
        logic [31:0] f;
        f = (32'(rs) << 21) | (32'(rt) << 16);
        case (k)
            0: return f | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
            1: return (32'h23 << 26) | f | 32'(imm);
            2: return (32'h2B << 26) | f | 32'(imm);
            3: return (32'h04 << 26) | f | 32'(imm);
            4: return (32'h0D << 26) | f | 32'(imm);
            5: return (32'h02 << 26) | 32'(tg);
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk_status(input string tag);
        chk({tag, "_busy"}, busy, m_load);
        chk({tag, "_done"}, done, m_done);
        chk({tag, "_err"}, err, m_err);
        chk({tag, "_code"}, err_code, m_code);
        chk({tag, "_count"}, count, m_count);
    endtask

    // called at a negedge; returns at the following negedge
    task automatic beat(
        input bit v, input int k, input logic [4:0] rs, input logic [4:0] rt,
        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
        input logic [15:0] imm, input logic [25:0] tg, input bit last,
        input logic [31:0] exp_w);
        bit acc, wr;
        int exp_a;
        in_valid = v; in_kind = 3'(k); in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_funct = fn; in_imm = imm; in_target = tg;
        in_last = last;
        chk("ready", in_ready, m_load);
        acc = v && m_load;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        wr = acc && (k < 6);
        exp_a = m_addr;
        if (acc) begin
            if (k >= 6) begin
                m_load = 0; m_err = 1; m_code = 1;
            end else begin
                m_count++;
                if (last) begin
                    m_load = 0; m_done = 1;
                end else if (m_count == DEP) begin
                    m_load = 0; m_err = 1; m_code = 2;
                end
            end
        end
        chk("we", imem_we, wr);
        if (wr) begin
            chk("addr", imem_addr, exp_a);
            chk("wdata", imem_wdata, exp_w);
            m_addr = (m_addr == AMAX) ? AMAX : m_addr + 1;
        end
        chk_status("beat");
    endtask

    task automatic start_pulse(input bit with_beat);
        start = 1'b1;
        in_valid = with_beat;
        in_kind = 3'd0;
        in_last = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        m_load = 1; m_done = 0; m_err = 0;
        m_code = 0; m_count = 0; m_addr = BASE;
        chk("start_we", imem_we, 0);
        chk("start_addr", imem_addr, BASE);
        chk_status("start");
    endtask

    task automatic rand_beat(input bit last);
        int k;
        logic [4:0] rs, rt, rd, sh;
        logic [5:0] fn;
        logic [15:0] imm;
        logic [25:0] tg;
        bit v;
        v = ($urandom_range(0, 4) != 0);
        k = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 7))
                                        : int'($urandom_range(0, 5));
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        sh = 5'($urandom); fn = 6'($urandom); imm = 16'($urandom);
        tg = 26'($urandom);
        beat(v, k, rs, rt, rd, sh, fn, imm, tg, last,
             enc(k, rs, rt, rd, sh, fn, imm, tg));
    endtask

    initial begin
        m_load = 0; m_done = 0; m_err = 0;
        m_code = 0; m_count = 0; m_addr = BASE;
        @(negedge clk);
        @(negedge clk);
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, BASE);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_ready", in_ready, 0);
        chk_status("rst");
        rst = 1'b0;

        beat(1, 0, 1, 2, 3, 0, 6'h20, 0, 0, 0, 32'h0);

        start_pulse(0);
        beat(1, 0, 1, 2, 3, 0, 6'h20, 16'h0, 26'h0, 0, 32'h00221820);
        beat(1, 1, 1, 2, 0, 0, 6'h0, 16'h0004, 26'h0, 0, 32'h8C220004);
        beat(1, 2, 1, 2, 0, 0, 6'h0, 16'h0008, 26'h0, 0, 32'hAC220008);
        beat(1, 3, 1, 2, 0, 0, 6'h0, 16'hFFFF, 26'h0, 0, 32'h1022FFFF);
        beat(1, 4, 0, 5, 0, 0, 6'h0, 16'h00FF, 26'h0, 0, 32'h340500FF);
        beat(1, 5, 0, 0, 0, 0, 6'h0, 16'h0, 26'h10, 1, 32'h08000010);
        beat(1, 0, 1, 2, 3, 0, 6'h20, 16'h0, 26'h0, 0, 32'h00221820);

        start_pulse(1);
        for (int i = 0; i < DEP + 1; i++)
            beat(1, 1, 5'(i), 5'(i + 1), 0, 0, 0, 16'(i), 0, 0,
                 enc(1, 5'(i), 5'(i + 1), 0, 0, 0, 16'(i), 0));

        start_pulse(0);
        beat(1, 6, 1, 2, 3, 0, 0, 0, 0, 0, 32'h0);
        beat(1, 0, 1, 2, 3, 0, 6'h20, 0, 0, 0, 32'h00221820);

        start_pulse(0);
        in_valid = 1'b1; in_kind = 3'd0; in_last = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("pre_rst_we", imem_we, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_we", imem_we, 0);
        chk("arst_addr", imem_addr, BASE);
        chk("arst_wdata", imem_wdata, 0);
        chk("arst_ready", in_ready, 0);
        m_load = 0; m_done = 0; m_err = 0;
        m_code = 0; m_count = 0; m_addr = BASE;
        chk_status("arst");
        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 40; s++) begin
            int n, last_at;
            start_pulse(bit'($urandom_range(0, 1)));
            n = $urandom_range(1, DEP + 2);
            last_at = $urandom_range(0, DEP + 2);
            for (int i = 0; i < n; i++)
                rand_beat(i == last_at);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
